// File: rtl/mmc_pkg.sv
// rtl/mmc_pkg.sv - shared state encoding and frame constants for the MMC command engine
package mmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_WAIT = 3'd2,
        ST_RX   = 3'd3,
        ST_FIN  = 3'd4
    } mmc_state_t;

    localparam logic [6:0] CRC7_POLY   = 7'h09;
    localparam int         FRAME_LEN   = 48;
    localparam int         RSP_W       = 38;
    localparam logic [5:0] LAST_BIT    = 6'(FRAME_LEN - 1);
    // The response start bit is consumed while waiting, so reception counts one bit fewer.
    localparam logic [5:0] RX_LAST_BIT = 6'(FRAME_LEN - 2);

endpackage

// File: rtl/mmc_crc7_ser.sv
// rtl/mmc_crc7_ser.sv - bit-serial CRC7 (x^7+x^3+1) with synchronous clear and enable
module mmc_crc7_ser
    import mmc_pkg::*;
(
    input  logic       wb_clk_i,
    input  logic       wb_rst_n_i,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic fb;

    assign fb = din ^ crc[6];

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/mmc_cmd_engine.sv
// rtl/mmc_cmd_engine.sv - autonomous MMC CMD-line engine: sends a 48-bit command, optionally captures the response
// Optional response CRC7/end-bit checker: define MMC_CMD_RSP_CRC_EN.
module mmc_cmd_engine
    import mmc_pkg::*;
#(
    parameter int RSP_TIMEOUT = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             start,
    input  logic [5:0]       cmd_idx,
    input  logic [31:0]      cmd_arg,
    input  logic             rsp_en,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             crc_err,
    output logic [RSP_W-1:0] rsp,
    output logic             clk_tick,
    input  logic             clk_done,
    output logic             mmc_cmd_o,
    output logic             mmc_cmd_oe,
    input  logic             mmc_cmd_i
);

    localparam logic [7:0] WAIT_LAST = 8'(RSP_TIMEOUT - 1);

    mmc_state_t  state, state_nx;
    logic [39:0] frame;
    logic        rsp_en_q;
    logic [5:0]  cnt;
    logic [7:0]  wcnt;
    logic        waiting;
    logic [45:0] rx_sr;
    logic [6:0]  tx_crc;
    logic [47:0] tx_word;
    logic        accept;
    logic        in_slot;
    logic        bit_done;
    logic        tx_crc_en;

    assign accept    = (state == ST_IDLE) && start;
    assign in_slot   = (state == ST_TX) || (state == ST_WAIT) || (state == ST_RX);
    // waiting marks the single outstanding tick; a clk_done without one is stale.
    assign bit_done  = in_slot && waiting && clk_done;
    assign tx_word   = {frame, tx_crc, 1'b1};
    assign tx_crc_en = bit_done && (state == ST_TX) && (cnt >= 6'd8);
    assign rsp       = rx_sr[45:8];

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        busy       = (state != ST_IDLE);
        done       = 1'b0;
        clk_tick   = in_slot && !waiting;
        mmc_cmd_oe = 1'b0;
        mmc_cmd_o  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_TX;
            end
            ST_TX: begin
                mmc_cmd_oe = 1'b1;
                mmc_cmd_o  = tx_word[cnt];
                if (bit_done && (cnt == 6'd0)) state_nx = rsp_en_q ? ST_WAIT : ST_FIN;
            end
            ST_WAIT: begin
                if (bit_done) begin
                    if (!mmc_cmd_i) begin
                        state_nx = ST_RX;
                    end else if (wcnt == WAIT_LAST) begin
                        state_nx = ST_FIN;
                    end
                end
            end
            ST_RX: begin
                if (bit_done && (cnt == 6'd0)) state_nx = ST_FIN;
            end
            ST_FIN: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            frame    <= '0;
            rsp_en_q <= 1'b0;
            cnt      <= '0;
            wcnt     <= '0;
            waiting  <= 1'b0;
            rx_sr    <= '0;
            timeout  <= 1'b0;
        end else if (accept) begin
            frame    <= {2'b01, cmd_idx, cmd_arg};
            rsp_en_q <= rsp_en;
            cnt      <= LAST_BIT;
            wcnt     <= '0;
            waiting  <= 1'b0;
            rx_sr    <= '0;
            timeout  <= 1'b0;
        end else if (in_slot) begin
            if (clk_tick) waiting <= 1'b1;
            if (bit_done) begin
                waiting <= 1'b0;
                case (state)
                    ST_WAIT: begin
                        if (!mmc_cmd_i) begin
                            cnt <= RX_LAST_BIT;
                        end else begin
                            wcnt <= wcnt + 8'd1;
                            if (wcnt == WAIT_LAST) timeout <= 1'b1;
                        end
                    end
                    ST_RX: begin
                        rx_sr <= {rx_sr[44:0], mmc_cmd_i};
                        cnt   <= cnt - 6'd1;
                    end
                    default: cnt <= cnt - 6'd1;
                endcase
            end
        end else begin
            waiting <= 1'b0;
        end
    end

    mmc_crc7_ser u_tx_crc (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .clr        (accept),
        .en         (tx_crc_en),
        .din        (mmc_cmd_o),
        .crc        (tx_crc)
    );

`ifdef MMC_CMD_RSP_CRC_EN
    logic [6:0] rx_crc;
    logic       rx_crc_en;

    // Covers the start bit (seen while waiting) plus transmit bit and the 38 payload bits.
    assign rx_crc_en = bit_done && (((state == ST_WAIT) && !mmc_cmd_i) ||
                                    ((state == ST_RX) && (cnt >= 6'd8)));

    mmc_crc7_ser u_rx_crc (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .clr        (accept),
        .en         (rx_crc_en),
        .din        (mmc_cmd_i),
        .crc        (rx_crc)
    );

    // On the end bit, rx_sr[6:0] already holds the received CRC7.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            crc_err <= 1'b0;
        end else if (accept) begin
            crc_err <= 1'b0;
        end else if ((state == ST_RX) && bit_done && (cnt == 6'd0)) begin
            crc_err <= (rx_crc != rx_sr[6:0]) || !mmc_cmd_i;
        end
    end
`else
    assign crc_err = 1'b0;
`endif

endmodule
